musa_program_loader: RTL and testbench

- Byte-stream writer for the MUSA instruction memory: the producer side of the instruction fetch path, where the core's PC only reads.
- Receives a framed program image over a valid/ready byte interface and assembles big-endian 32-bit words.
- Writes the words to instruction memory from word address 0, holding the core in reset while it loads.
- Releases the core reset only when the frame checksum is correct; reports errors otherwise.

---
 rtl/musa_program_loader.sv | 216 +++++++++++++++++++++
 tb/tb_musa_program_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/musa_program_loader.sv
// Program loader for the MUSA instruction memory: parses a framed byte stream,
// writes big-endian words from address 0 and releases the core on a good checksum.
module musa_program_loader #(
    parameter int ADDR_WIDTH     = 18,
    parameter int DEPTH_WORDS    = 1024,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] imem_address,
    output logic [31:0]           imem_data,
    output logic                  imem_wren,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    localparam int               TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]      DEPTH_MAX  = 17'(DEPTH_WORDS);
    localparam logic [7:0]       SYNC_BYTE  = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_RUN
    } state_t;

    state_t                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [15:0]           n_q, n_d;
    logic [15:0]           word_idx_q, word_idx_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [23:0]           shift_q, shift_d;
    logic [7:0]            chk_q, chk_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]           imem_data_q, imem_data_d;
    logic                  imem_wren_q, imem_wren_d;
    logic                  core_rst_n_q, core_rst_n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [1:0]            err_code_q, err_code_d;

    logic                  accept;
    logic [15:0]           len_now;
    logic                  in_frame;

    assign accept   = in_valid && in_ready_q;
    assign len_now  = {len_hi_q, in_byte};
    assign in_frame = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA)   || (state_q == ST_CHECK);

    always_comb begin
        state_d      = state_q;
        in_ready_d   = 1'b1;
        len_hi_d     = len_hi_q;
        n_d          = n_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        chk_d        = chk_q;
        tmo_d        = '0;
        imem_addr_d  = imem_addr_q;
        imem_data_d  = imem_data_q;
        imem_wren_d  = 1'b0;
        core_rst_n_d = core_rst_n_q;
        done_d       = done_q;
        error_d      = error_q;
        err_code_d   = err_code_q;

        // An accepted byte always beats an expiring idle counter.
        if (in_frame && !accept) begin
            if (tmo_q == TMO_LAST) begin
                state_d      = ST_IDLE;
                error_d      = 1'b1;
                err_code_d   = 2'b11;
                core_rst_n_d = 1'b0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_byte == SYNC_BYTE) begin
                        state_d    = ST_LEN_HI;
                        error_d    = 1'b0;
                        err_code_d = 2'b00;
                        chk_d      = 8'h00;
                    end
                end
                ST_RUN: begin
                    if (in_byte == SYNC_BYTE) begin
                        state_d      = ST_LEN_HI;
                        core_rst_n_d = 1'b0;
                        done_d       = 1'b0;
                        chk_d        = 8'h00;
                    end
                end
                ST_LEN_HI: begin
                    len_hi_d = in_byte;
                    state_d  = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    n_d        = len_now;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    if ({1'b0, len_now} > DEPTH_MAX) begin
                        state_d    = ST_IDLE;
                        error_d    = 1'b1;
                        err_code_d = 2'b01;
                    end else if (len_now == 16'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    chk_d = chk_q ^ in_byte;
                    if (byte_idx_q == 2'd3) begin
                        imem_wren_d = 1'b1;
                        imem_addr_d = ADDR_WIDTH'(word_idx_q);
                        imem_data_d = {shift_q, in_byte};
                        byte_idx_d  = 2'd0;
                        word_idx_d  = word_idx_q + 16'd1;
                        if (word_idx_q == n_q - 16'd1) begin
                            state_d = ST_CHECK;
                        end
                    end else begin
                        shift_d    = {shift_q[15:0], in_byte};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
                ST_CHECK: begin
                    if (in_byte == chk_q) begin
                        state_d      = ST_RUN;
                        core_rst_n_d = 1'b1;
                        done_d       = 1'b1;
                    end else begin
                        state_d      = ST_IDLE;
                        error_d      = 1'b1;
                        err_code_d   = 2'b10;
                        core_rst_n_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_LEN_HI) || (state_d == ST_LEN_LO) ||
                 (state_d == ST_DATA)   || (state_d == ST_CHECK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            in_ready_q   <= 1'b0;
            len_hi_q     <= '0;
            n_q          <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
            chk_q        <= '0;
            tmo_q        <= '0;
            imem_addr_q  <= '0;
            imem_data_q  <= '0;
            imem_wren_q  <= 1'b0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            len_hi_q     <= len_hi_d;
            n_q          <= n_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            chk_q        <= chk_d;
            tmo_q        <= tmo_d;
            imem_addr_q  <= imem_addr_d;
            imem_data_q  <= imem_data_d;
            imem_wren_q  <= imem_wren_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            err_code_q   <= err_code_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_address = imem_addr_q;
    assign imem_data    = imem_data_q;
    assign imem_wren    = imem_wren_q;
    assign core_rst_n   = core_rst_n_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_code     = err_code_q;

endmodule

// File: tb/tb_musa_program_loader.sv
// Scoreboard bench for musa_program_loader: a frame-level model predicts memory
// writes and the final status; a monitor checks every write strobe in order.
module tb_musa_program_loader;

    localparam int AW  = 18;
    localparam int DW  = 1024;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [7:0]    in_byte;
    logic          in_ready;
    logic [AW-1:0] imem_address;
    logic [31:0]   imem_data;
    logic          imem_wren;
    logic          core_rst_n;
    logic          busy;
    logic          done;
    logic          error;
    logic [1:0]    err_code;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        expQ[$];
    wr_t        monExp;
    logic [7:0] frameBytes[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    musa_program_loader #(
        .ADDR_WIDTH    (AW),
        .DEPTH_WORDS   (DW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_ready    (in_ready),
        .imem_address(imem_address),
        .imem_data   (imem_data),
        .imem_wren   (imem_wren),
        .core_rst_n  (core_rst_n),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_code    (err_code)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every write strobe must match the oldest write the model predicted.
    always @(negedge clk) begin
        if (imem_wren === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write actual=%0h:%0h expected=none", imem_address, imem_data);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("wr_addr", 64'(imem_address), 64'(monExp.addr));
                checkOutput("wr_data", 64'(imem_data), 64'(monExp.data));
            end
        end
    end

    task automatic sendByte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
    endtask

    // Sends frameBytes[first..last-1]; predicts a write whenever a word's 4th data byte goes out.
    task automatic applyStimulus(input int first, input int last, input int maxGap);
        int n;
        n = int'({frameBytes[1], frameBytes[2]});
        for (int i = first; i < last; i++) begin
            int  di;
            wr_t w;
            di = i - 3;
            if (n <= DW && di >= 0 && di < 4 * n && (di % 4) == 3) begin
                w.addr = AW'(di / 4);
                w.data = {frameBytes[i-3], frameBytes[i-2], frameBytes[i-1], frameBytes[i]};
                expQ.push_back(w);
            end
            sendByte(frameBytes[i], int'($urandom_range(maxGap, 0)));
        end
    endtask

    function automatic void modelOutcome(output logic expDone, output logic expErr, output logic [1:0] expCode);
        int         n;
        logic [7:0] x;
        n = int'({frameBytes[1], frameBytes[2]});
        x = 8'h00;
        if (n > DW) begin
            expDone = 1'b0; expErr = 1'b1; expCode = 2'b01;
            return;
        end
        for (int i = 0; i < 4 * n; i++) x ^= frameBytes[3 + i];
        if (frameBytes[3 + 4 * n] == x) begin
            expDone = 1'b1; expErr = 1'b0; expCode = 2'b00;
        end else begin
            expDone = 1'b0; expErr = 1'b1; expCode = 2'b10;
        end
    endfunction

    task automatic settleAndCheck(input string name);
        logic       d, e;
        logic [1:0] c;
        modelOutcome(d, e, c);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput({name, "_done"}, 64'(done), 64'(d));
        checkOutput({name, "_core_rst_n"}, 64'(core_rst_n), 64'(d));
        checkOutput({name, "_error"}, 64'(error), 64'(e));
        checkOutput({name, "_err_code"}, 64'(err_code), 64'(c));
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic runFrame(input string name, input int maxGap);
        applyStimulus(0, frameBytes.size(), maxGap);
        settleAndCheck(name);
    endtask

    task automatic buildFrame(input int n, input bit corrupt);
        logic [7:0] x, b;
        logic [15:0] len;
        len = 16'(n);
        x = 8'h00;
        frameBytes.delete();
        frameBytes.push_back(8'hA5);
        frameBytes.push_back(len[15:8]);
        frameBytes.push_back(len[7:0]);
        if (n > DW) return;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            frameBytes.push_back(b);
            x ^= b;
        end
        frameBytes.push_back(corrupt ? (x ^ 8'($urandom_range(255, 1))) : x);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput(name, 64'({in_ready, imem_wren, core_rst_n, busy, done, error, err_code, imem_address, imem_data}), 64'd0);
    endtask

    task automatic sendGarbage(input int count);
        logic [7:0] b;
        for (int i = 0; i < count; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            sendByte(b, int'($urandom_range(2, 0)));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset_outputs");
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("ready_after_reset", 64'(in_ready), 64'd1);
        checkOutput("core_held_after_reset", 64'(core_rst_n), 64'd0);

        frameBytes = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h26};
        runFrame("load2", 0);

        frameBytes[11] = 8'h00;
        runFrame("bad_chk", 1);

        frameBytes = '{8'hA5, 8'h04, 8'h01};
        runFrame("too_long", 0);

        sendByte(8'h00, 0);
        sendByte(8'hFF, 1);
        sendByte(8'h13, 0);
        @(negedge clk);
        checkOutput("garbage_busy", 64'(busy), 64'd0);
        checkOutput("garbage_error_kept", 64'(error), 64'd1);
        frameBytes = '{8'hA5, 8'h00, 8'h00, 8'h00};
        runFrame("len0", 0);

        frameBytes = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h26};
        applyStimulus(0, 5, 0);
        repeat (TMO + 4) @(posedge clk);
        @(negedge clk);
        checkOutput("tmo_error", 64'(error), 64'd1);
        checkOutput("tmo_code", 64'(err_code), 64'd3);
        checkOutput("tmo_busy", 64'(busy), 64'd0);
        checkOutput("tmo_core", 64'(core_rst_n), 64'd0);
        runFrame("slow_ok", TMO - 2);

        frameBytes = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        applyStimulus(0, 1, 0);
        @(negedge clk);
        checkOutput("reload_core_low", 64'(core_rst_n), 64'd0);
        checkOutput("reload_done_low", 64'(done), 64'd0);
        checkOutput("reload_busy", 64'(busy), 64'd1);
        applyStimulus(1, frameBytes.size(), 0);
        settleAndCheck("reload");

        for (int k = 0; k < 8; k++) begin
            int n;
            sendGarbage(int'($urandom_range(3, 0)));
            n = int'($urandom_range(4, 0));
            if ($urandom_range(5, 0) == 0) n = DW + 1 + int'($urandom_range(50, 0));
            buildFrame(n, $urandom_range(2, 0) == 0);
            runFrame($sformatf("rand%0d", k), 2);
        end

        frameBytes = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h26};
        applyStimulus(0, 8, 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkAllZero("mid_data_reset");
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_reset_ready", 64'(in_ready), 64'd1);
        checkOutput("post_reset_core", 64'(core_rst_n), 64'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
